// File: rtl/result_uart_formatter.sv
// result_uart_formatter
//   Consumer end of the compute-result interface. On a display_en strobe it
//   latches a result matrix (or an error status) and serialises it as ASCII
//   text onto a valid/ready byte stream that feeds the UART transmitter.
//   Elements print in unsigned decimal, row-major, separated by SEP_CHAR,
//   each row closed by CR LF. Error frames print "E<code>\r\n".
//
//   Optional build macro RESULT_HDR_EN: when defined, every valid matrix
//   frame is preceded by the header "<m>x<n>\r\n".
//
// Ports
//   clk             system clock
//   rst_n           synchronous active-low reset
//   display_en      single-cycle strobe, inputs below valid this cycle
//   display_type    01 = matrix, 10 = error, 00/11 ignored
//   error_type      error code printed on error frames
//   result_m/_n     result rows / columns
//   result_mat_flat element r*n+c at bits [(r*n+c)*ELEM_W +: ELEM_W]
//   tx_data/tx_valid/tx_ready  output byte stream
//   busy            frame latched and not fully sent
//   frame_done      one-cycle pulse after the last byte is accepted
//
// States
//   IDLE     | waiting for display_en
//   LATCH    | dimension check (and header bytes when enabled)
//   CONV     | 16-cycle double-dabble of the current element
//   EMIT_DIG | decimal digits, leading zeros suppressed
//   EMIT_SEP | separator between elements of a row
//   EMIT_CR  | carriage return at end of row
//   EMIT_LF  | line feed at end of row
//   EMIT_ERR | "E", code digit, CR, LF
//   DONE     | frame_done pulse, back to IDLE

module result_uart_formatter #(
    parameter logic [7:0] SEP_CHAR = 8'h20,
    parameter int         MAX_DIM  = 5,
    parameter int         ELEM_W   = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                display_en,
    input  logic [1:0]                          display_type,
    input  logic [2:0]                          error_type,
    input  logic [3:0]                          result_m,
    input  logic [3:0]                          result_n,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   result_mat_flat,
    output logic [7:0]                          tx_data,
    output logic                                tx_valid,
    input  logic                                tx_ready,
    output logic                                busy,
    output logic                                frame_done
);

    localparam int         FLAT_W    = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int         NDIG      = 5;
    localparam logic [3:0] MAX_DIM_L = 4'(MAX_DIM);
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_ZERO   = 8'h30;

    typedef enum logic [3:0] {
        IDLE, LATCH, CONV, EMIT_DIG, EMIT_SEP, EMIT_CR, EMIT_LF, EMIT_ERR, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   is_err_q, is_err_d;
    logic [2:0]             code_q, code_d;
    logic [3:0]             m_q, m_d, n_q, n_d;
    logic [FLAT_W-1:0]      mat_q, mat_d;
    logic [2:0]             row_q, row_d, col_q, col_d;
    logic [4:0]             elem_q, elem_d;
    logic [ELEM_W-1:0]      bin_q, bin_d;
    logic [NDIG*4-1:0]      bcd_q, bcd_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             dig_q, dig_d;
    logic                   started_q, started_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
`ifdef RESULT_HDR_EN
    logic                   hdr_q, hdr_d;
`endif

    logic                   emit_en;
    logic [7:0]             emit_byte;
    logic                   xfer;
    logic                   load_conv;
    logic [4:0]             load_idx;
    logic [2:0]             dig_sel;
    logic [3:0]             digit;
    logic                   dims_bad;

    // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
    // the whole {bcd, bin} register left by one.
    function automatic logic [NDIG*4+ELEM_W-1:0] dd_step(input logic [NDIG*4-1:0] bcd,
                                                          input logic [ELEM_W-1:0] bin);
        logic [NDIG*4-1:0] adj;
        adj = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
        return {adj, bin} << 1;
    endfunction

    // Position of the most significant non-zero digit; 0 when the value is 0
    // so that a zero element still prints a single '0'.
    function automatic logic [2:0] msd(input logic [NDIG*4-1:0] bcd);
        logic [2:0] pos;
        pos = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) pos = 3'(i);
        end
        return pos;
    endfunction

    assign xfer     = tx_valid_q && tx_ready;
    assign dig_sel  = started_q ? dig_q : msd(bcd_q);
    assign digit    = bcd_q[dig_sel*4 +: 4];
    assign dims_bad = (m_q == 4'd0) || (m_q > MAX_DIM_L) ||
                      (n_q == 4'd0) || (n_q > MAX_DIM_L);

    always_comb begin
        state_d    = state_q;
        is_err_d   = is_err_q;
        code_d     = code_q;
        m_d        = m_q;
        n_d        = n_q;
        mat_d      = mat_q;
        row_d      = row_q;
        col_d      = col_q;
        elem_d     = elem_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        dig_d      = dig_q;
        started_d  = started_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
`ifdef RESULT_HDR_EN
        hdr_d      = hdr_q;
`endif
        emit_en    = 1'b0;
        emit_byte  = 8'h00;
        load_conv  = 1'b0;
        load_idx   = 5'd0;

        case (state_q)
            IDLE: begin
                if (display_en && (display_type == 2'b01 || display_type == 2'b10)) begin
                    is_err_d = (display_type == 2'b10);
                    code_d   = error_type;
                    m_d      = result_m;
                    n_d      = result_n;
                    mat_d    = result_mat_flat;
                    idx_d    = 3'd0;
                    state_d  = LATCH;
                end
            end

            LATCH: begin
`ifdef RESULT_HDR_EN
                if (hdr_q) begin
                    emit_en = 1'b1;
                    case (idx_q)
                        3'd0:    emit_byte = CH_ZERO + {4'h0, m_q};
                        3'd1:    emit_byte = 8'h78;
                        3'd2:    emit_byte = CH_ZERO + {4'h0, n_q};
                        3'd3:    emit_byte = CH_CR;
                        default: emit_byte = CH_LF;
                    endcase
                    if (xfer) begin
                        if (idx_q == 3'd4) begin
                            idx_d     = 3'd0;
                            hdr_d     = 1'b0;
                            load_conv = 1'b1;
                            load_idx  = 5'd0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end else
`endif
                begin
                    row_d = 3'd0;
                    col_d = 3'd0;
                    if (is_err_q) begin
                        state_d = EMIT_ERR;
                    end else if (dims_bad) begin
                        code_d  = 3'd7;
                        state_d = EMIT_ERR;
                    end else begin
`ifdef RESULT_HDR_EN
                        hdr_d = 1'b1;
`else
                        load_conv = 1'b1;
                        load_idx  = 5'd0;
`endif
                    end
                end
            end

            CONV: begin
                {bcd_d, bin_d} = dd_step(bcd_q, bin_q);
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = EMIT_DIG;
            end

            EMIT_DIG: begin
                emit_en   = 1'b1;
                emit_byte = CH_ZERO + {4'h0, digit};
                if (!tx_valid_q) begin
                    dig_d     = dig_sel;
                    started_d = 1'b1;
                end else if (tx_ready) begin
                    if (dig_q == 3'd0) begin
                        started_d = 1'b0;
                        if ({1'b0, col_q} == n_q - 4'd1) state_d = EMIT_CR;
                        else                             state_d = EMIT_SEP;
                    end else begin
                        dig_d = dig_q - 3'd1;
                    end
                end
            end

            EMIT_SEP: begin
                emit_en   = 1'b1;
                emit_byte = SEP_CHAR;
                if (xfer) begin
                    col_d     = col_q + 3'd1;
                    load_conv = 1'b1;
                    load_idx  = elem_q + 5'd1;
                end
            end

            EMIT_CR: begin
                emit_en   = 1'b1;
                emit_byte = CH_CR;
                if (xfer) state_d = EMIT_LF;
            end

            EMIT_LF: begin
                emit_en   = 1'b1;
                emit_byte = CH_LF;
                if (xfer) begin
                    if ({1'b0, row_q} == m_q - 4'd1) begin
                        state_d = DONE;
                    end else begin
                        row_d     = row_q + 3'd1;
                        col_d     = 3'd0;
                        load_conv = 1'b1;
                        load_idx  = elem_q + 5'd1;
                    end
                end
            end

            EMIT_ERR: begin
                emit_en = 1'b1;
                case (idx_q)
                    3'd0:    emit_byte = 8'h45;
                    3'd1:    emit_byte = CH_ZERO + {5'h0, code_q};
                    3'd2:    emit_byte = CH_CR;
                    default: emit_byte = CH_LF;
                endcase
                if (xfer) begin
                    if (idx_q == 3'd3) begin
                        idx_d   = 3'd0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            DONE:    state_d = IDLE;

            default: state_d = IDLE;
        endcase

        if (load_conv) begin
            elem_d  = load_idx;
            bin_d   = mat_q[load_idx*ELEM_W +: ELEM_W];
            bcd_d   = '0;
            cnt_d   = 5'(ELEM_W);
            state_d = CONV;
        end

        // A byte is presented one cycle after the state asks for it and held
        // untouched until accepted, which keeps tx_data stable under stall.
        if (emit_en) begin
            if (!tx_valid_q) begin
                tx_data_d  = emit_byte;
                tx_valid_d = 1'b1;
            end else if (tx_ready) begin
                tx_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_err_q   <= 1'b0;
            code_q     <= '0;
            m_q        <= '0;
            n_q        <= '0;
            mat_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            elem_q     <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            dig_q      <= '0;
            started_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
`ifdef RESULT_HDR_EN
            hdr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            is_err_q   <= is_err_d;
            code_q     <= code_d;
            m_q        <= m_d;
            n_q        <= n_d;
            mat_q      <= mat_d;
            row_q      <= row_d;
            col_q      <= col_d;
            elem_q     <= elem_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            dig_q      <= dig_d;
            started_q  <= started_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
`ifdef RESULT_HDR_EN
            hdr_q      <= hdr_d;
`endif
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_result_uart_formatter.sv
// Testbench for result_uart_formatter: builds the expected text of each frame
// from decimal formatting rules and checks every accepted byte against it.
module tb_result_uart_formatter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         display_en = 1'b0;
    logic [1:0]   display_type = 2'b00;
    logic [2:0]   error_type = 3'd0;
    logic [3:0]   result_m = 4'd0;
    logic [3:0]   result_n = 4'd0;
    logic [399:0] result_mat_flat = '0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         busy;
    logic         frame_done;

    result_uart_formatter dut (
        .clk(clk), .rst_n(rst_n), .display_en(display_en),
        .display_type(display_type), .error_type(error_type),
        .result_m(result_m), .result_n(result_n),
        .result_mat_flat(result_mat_flat),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    byte unsigned exp_q[$];
    int fd_cnt = 0;
    int byte_cnt = 0;
    int rdy_mode = 0;
    int elems[25];

`ifdef RESULT_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: model text differs from hand-written text (len %0d vs %0d)",
                     name, act.len(), exp.len());
        end
    endtask

    function automatic bit dims_ok(input int m, input int n);
        return (m >= 1 && m <= 5 && n >= 1 && n <= 5);
    endfunction

    // Expected frame text from the formatting rules.
    function automatic string model(input int typ, input int code, input int m, input int n);
        string s;
        if (typ == 1 && !dims_ok(m, n)) begin
            typ  = 2;
            code = 7;
        end
        if (typ == 2) return $sformatf("E%0d\015\012", code);
        s = "";
        if (HDR) s = $sformatf("%0dx%0d\015\012", m, n);
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                s = {s, $sformatf("%0d", elems[r*n+c])};
                if (c < n - 1) s = {s, " "};
            end
            s = {s, "\015\012"};
        end
        return s;
    endfunction

    task automatic push_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic drive_frame(input int typ, input int code, input int m, input int n);
        result_mat_flat = '0;
        for (int i = 0; i < 25; i++)
            if (i < m * n) result_mat_flat[i*16 +: 16] = 16'(elems[i]);
        display_type = 2'(typ);
        error_type   = 3'(code);
        result_m     = 4'(m);
        result_n     = 4'(n);
        display_en   = 1'b1;
        @(posedge clk);
        #1 display_en = 1'b0;
    endtask

    // Monitor: every accepted byte, stall stability, frame_done alignment.
    initial begin
        bit          hold;
        logic [7:0]  hold_data;
        byte unsigned e;
        hold = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_valid_held", tx_valid, 1);
                    chk("stall_data_held", tx_data, hold_data);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", tx_data, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", tx_data, e);
                    end
                    byte_cnt++;
                end
                hold = tx_valid && !tx_ready;
                hold_data = tx_data;
                if (frame_done) begin
                    fd_cnt++;
                    chk("bytes_left_at_done", exp_q.size(), 0);
                end
            end
        end
    end

    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ($urandom_range(0, 9) < 7);
                default: begin
                    tx_ready = ((k % 4) == 0) || ((k % 4) == 3);
                    k++;
                end
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    // poke: 1 = strobe display_en mid-frame, 2 = strobe during the DONE cycle
    task automatic run_frame(input int typ, input int code, input int m, input int n,
                             input int poke);
        string s;
        int lat, exp_lat, fd0, b0, w, vis;
        s = model(typ, code, m, n);
        push_exp(s);
        fd0 = fd_cnt;
        b0  = byte_cnt;
        drive_frame(typ, code, m, n);
        exp_lat = (typ == 2 || !dims_ok(m, n) || HDR) ? 2 : 18;
        lat = 0;
        while (!tx_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("first_valid_latency", lat, exp_lat);
        if (poke == 1) begin
            repeat (3) @(posedge clk);
            #1;
            for (int i = 0; i < 25; i++) elems[i] = $urandom_range(0, 65535);
            drive_frame(1, 0, 3, 3);
        end
        w = 0;
        while (!frame_done && w < 8000) begin
            @(posedge clk);
            #1 w++;
        end
        chk("frame_done_seen", frame_done, 1);
        chk("busy_in_done", busy, 0);
        if (poke == 2) begin
            for (int i = 0; i < 25; i++) elems[i] = 7;
            drive_frame(1, 0, 2, 2);
        end else begin
            @(posedge clk);
            #1;
        end
        chk("frame_done_pulse", frame_done, 0);
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("frame_bytes", byte_cnt - b0, s.len());
        if (poke != 0) begin
            vis = 0;
            repeat (40) begin
                @(posedge clk);
                #1 if (tx_valid || busy) vis++;
            end
            chk("ignored_strobe_no_frame", vis, 0);
        end
        exp_q.delete();
    endtask

    initial begin
        string pin;
        int b0, w, m, n, typ, cls;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2x2 [1,23;456,65535]
        rdy_mode = 0;
        elems[0] = 1; elems[1] = 23; elems[2] = 456; elems[3] = 65535;
        pin = HDR ? "2x2\015\0121 23\015\012456 65535\015\012" : "1 23\015\012456 65535\015\012";
        chk_str("pin_2x2", model(1, 0, 2, 2), pin);
        run_frame(1, 0, 2, 2, 0);

        chk_str("pin_err2", model(2, 2, 2, 2), "E2\015\012");
        run_frame(2, 2, 2, 2, 0);
        chk_str("pin_dim0", model(1, 0, 0, 3), "E7\015\012");
        run_frame(1, 0, 0, 3, 0);

        // 1x1 zero with ready pattern 1-0-0-1
        rdy_mode = 2;
        elems[0] = 0;
        chk_str("pin_zero", model(1, 0, 1, 1), HDR ? "1x1\015\0120\015\012" : "0\015\012");
        run_frame(1, 0, 1, 1, 0);

`ifdef RESULT_HDR_EN
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) elems[i] = 1;
        chk_str("pin_hdr_2x3", model(1, 0, 2, 3), "2x3\015\0121 1 1\015\0121 1 1\015\012");
        run_frame(1, 0, 2, 3, 0);
`endif

        // second strobe mid-frame, then strobe in the DONE cycle
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) elems[i] = 100 * i + 9;
        run_frame(1, 0, 2, 2, 1);
        elems[0] = 42;
        run_frame(2, 5, 1, 1, 2);

        // ignored display types
        for (int t = 0; t < 4; t += 3) begin
            drive_frame(t, 1, 1, 1);
            repeat (2) @(posedge clk);
            #1;
            chk("ignored_type_busy", busy, 0);
            chk("ignored_type_valid", tx_valid, 0);
        end

        // reset during the third byte of a 3x3 frame
        for (int i = 0; i < 9; i++) elems[i] = 10 + i;
        push_exp(model(1, 0, 3, 3));
        b0 = byte_cnt;
        drive_frame(1, 0, 3, 3);
        w = 0;
        while (!((byte_cnt - b0) == 2 && tx_valid) && w < 500) begin
            @(posedge clk);
            #1 w++;
        end
        chk("third_byte_reached", w < 500, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_tx_valid", tx_valid, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_frame_done", frame_done, 0);
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) elems[i] = 1000 * i;
        run_frame(1, 0, 3, 3, 0);

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            rdy_mode = $urandom_range(0, 1);
            typ = ($urandom_range(0, 9) < 8) ? 1 : 2;
            m = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 5);
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 5);
            for (int i = 0; i < 25; i++) begin
                cls = $urandom_range(0, 5);
                case (cls)
                    0:       elems[i] = 0;
                    1:       elems[i] = 65535;
                    2:       elems[i] = $urandom_range(0, 9);
                    3:       elems[i] = $urandom_range(0, 999);
                    default: elems[i] = $urandom_range(0, 65535);
                endcase
            end
            run_frame(typ, $urandom_range(0, 7), m, n, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
